// File: rtl/snoop_dispatcher.sv
// Steers each snooped packet's write stream and done pulse to one ready BPF core,
// chosen round-robin; packets arriving with no core ready are dropped and counted.
module snoop_dispatcher #(
  parameter  int N_CORES              = 4,
  parameter  int SNOOP_FWD_ADDR_WIDTH = 9,
  parameter  int SNOOP_FWD_DATA_WIDTH = 64,
  parameter  int DROP_CNT_WIDTH       = 16,
  localparam int SEL_WIDTH            = $clog2(N_CORES)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            sn_sof,
  input  logic [SNOOP_FWD_ADDR_WIDTH-1:0] snooper_wr_addr,
  input  logic [SNOOP_FWD_DATA_WIDTH-1:0] snooper_wr_data,
  input  logic                            snooper_wr_en,
  input  logic                            snooper_done,
  output logic                            sn_ready,
  input  logic [N_CORES-1:0]              core_ready,
  output logic [SNOOP_FWD_ADDR_WIDTH-1:0] core_wr_addr,
  output logic [SNOOP_FWD_DATA_WIDTH-1:0] core_wr_data,
  output logic [N_CORES-1:0]              core_wr_en,
  output logic [N_CORES-1:0]              core_done,
  output logic [SEL_WIDTH-1:0]            cur_sel,
  output logic                            grant_valid,
  output logic [DROP_CNT_WIDTH-1:0]       drop_cnt,
  output logic                            proto_err
);

  typedef enum logic [1:0] {IDLE, GRANT, DROP} state_e;

  state_e                    state_q;
  logic [SEL_WIDTH-1:0]      rr_ptr_q;
  logic [SEL_WIDTH-1:0]      cur_sel_q;
  logic                      grant_valid_q;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt_q;
  logic                      proto_err_q;

  logic                      pick_found_d;
  logic [SEL_WIDTH-1:0]      pick_idx_d;
  logic [SEL_WIDTH-1:0]      rr_next_d;
  logic                      grant_active;

  // Scan from rr_ptr upward with wrap; iterating offsets downward lets the
  // smallest offset overwrite the others and win.
  always_comb begin
    int cand;
    cand         = 0;
    pick_found_d = 1'b0;
    pick_idx_d   = '0;
    for (int k = N_CORES - 1; k >= 0; k--) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= N_CORES) cand = cand - N_CORES;
      if (core_ready[cand]) begin
        pick_found_d = 1'b1;
        pick_idx_d   = SEL_WIDTH'(cand);
      end
    end
  end

  always_comb begin
    rr_next_d = '0;
    if (cur_sel_q != SEL_WIDTH'(N_CORES - 1)) rr_next_d = cur_sel_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      cur_sel_q     <= '0;
      grant_valid_q <= 1'b0;
      drop_cnt_q    <= '0;
      proto_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (snooper_done) proto_err_q <= 1'b1;
          if (sn_sof) begin
            if (pick_found_d) begin
              cur_sel_q     <= pick_idx_d;
              grant_valid_q <= 1'b1;
              state_q       <= GRANT;
            end else begin
              state_q <= DROP;
              if (drop_cnt_q != {DROP_CNT_WIDTH{1'b1}}) drop_cnt_q <= drop_cnt_q + 1'b1;
            end
          end
        end
        GRANT: begin
          if (sn_sof) proto_err_q <= 1'b1;
          if (snooper_done) begin
            state_q       <= IDLE;
            grant_valid_q <= 1'b0;
            rr_ptr_q      <= rr_next_d;
          end
        end
        DROP: begin
          if (sn_sof) proto_err_q <= 1'b1;
          if (snooper_done) state_q <= IDLE;
        end
        default: begin
          state_q       <= IDLE;
          grant_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Steering is combinational off the registered grant so writes reach the core with zero latency.
  assign grant_active = (state_q == GRANT);

  generate
    for (genvar gi = 0; gi < N_CORES; gi++) begin : g_core
      assign core_wr_en[gi] = grant_active && snooper_wr_en && (cur_sel_q == SEL_WIDTH'(gi));
      assign core_done[gi]  = grant_active && snooper_done  && (cur_sel_q == SEL_WIDTH'(gi));
    end
  endgenerate

  assign core_wr_addr = snooper_wr_addr;
  assign core_wr_data = snooper_wr_data;
  assign sn_ready     = (state_q == IDLE);
  assign cur_sel      = cur_sel_q;
  assign grant_valid  = grant_valid_q;
  assign drop_cnt     = drop_cnt_q;
  assign proto_err    = proto_err_q;

endmodule

// File: tb/tb_snoop_dispatcher.sv
// Scoreboard bench: stimulus queues expected core writes/dones, a negedge monitor pops and compares.
module tb_snoop_dispatcher;
  localparam int NC = 4;
  localparam int AW = 9;
  localparam int DW = 64;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sn_sof;
  logic [AW-1:0] snooper_wr_addr;
  logic [DW-1:0] snooper_wr_data;
  logic          snooper_wr_en;
  logic          snooper_done;
  logic          sn_ready;
  logic [NC-1:0] core_ready;
  logic [AW-1:0] core_wr_addr;
  logic [DW-1:0] core_wr_data;
  logic [NC-1:0] core_wr_en;
  logic [NC-1:0] core_done;
  logic [1:0]    cur_sel;
  logic          grant_valid;
  logic [CW-1:0] drop_cnt;
  logic          proto_err;

  snoop_dispatcher #(
    .N_CORES(NC), .SNOOP_FWD_ADDR_WIDTH(AW), .SNOOP_FWD_DATA_WIDTH(DW), .DROP_CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sn_sof(sn_sof),
    .snooper_wr_addr(snooper_wr_addr), .snooper_wr_data(snooper_wr_data),
    .snooper_wr_en(snooper_wr_en), .snooper_done(snooper_done), .sn_ready(sn_ready),
    .core_ready(core_ready), .core_wr_addr(core_wr_addr), .core_wr_data(core_wr_data),
    .core_wr_en(core_wr_en), .core_done(core_done), .cur_sel(cur_sel),
    .grant_valid(grant_valid), .drop_cnt(drop_cnt), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NC-1:0] en;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           wr_q[$];
  logic [NC-1:0] done_q[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [NC-1:0] onehot(input int t);
    logic [NC-1:0] v;
    v    = '0;
    v[t] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end else begin
      $display("check %s: %0h ok", name, act);
    end
  endtask

  // One clock of stimulus; tgt is the core expected to see this cycle's write/done (-1 none).
  task automatic cyc(input logic sof, input logic wr, input logic dn, input int tgt);
    wr_t e;
    @(posedge clk); #1;
    sn_sof          = sof;
    snooper_wr_en   = wr;
    snooper_done    = dn;
    snooper_wr_addr = AW'($urandom_range(0, (1 << AW) - 1));
    snooper_wr_data = {$urandom, $urandom};
    if (tgt >= 0 && wr) begin
      e.en   = onehot(tgt);
      e.addr = snooper_wr_addr;
      e.data = snooper_wr_data;
      wr_q.push_back(e);
    end
    if (tgt >= 0 && dn) done_q.push_back(onehot(tgt));
  endtask

  // Full packet: sof, nwr writes, done. c = expected core, -1 = expect drop.
  task automatic pkt(input logic [NC-1:0] rdy, input logic [NC-1:0] rdy_after,
                     input int nwr, input int c);
    cyc(1'b1, 1'b0, 1'b0, -1);
    core_ready = rdy;
    chk("sn_ready_at_sof", 64'(sn_ready), 64'd1);
    if (nwr > 0) cyc(1'b0, 1'b1, 1'b0, c);
    else         cyc(1'b0, 1'b0, 1'b1, c);
    chk("sn_ready_busy", 64'(sn_ready), 64'd0);
    chk("grant_valid", 64'(grant_valid), (c >= 0) ? 64'd1 : 64'd0);
    if (c >= 0) chk("cur_sel", 64'(cur_sel), 64'(c));
    core_ready = rdy_after;
    for (int i = 1; i < nwr; i++) cyc(1'b0, 1'b1, 1'b0, c);
    if (nwr > 0) cyc(1'b0, 1'b0, 1'b1, c);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; sn_sof = 1'b0; snooper_wr_en = 1'b0; snooper_done = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Monitor: every observed core write/done must match the head of its queue.
  wr_t           mon_e;
  logic [NC-1:0] mon_d;
  always @(negedge clk) begin
    if (core_wr_en != '0) begin
      checks++;
      if (wr_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: core_wr_en=%b, required none", core_wr_en);
      end else begin
        mon_e = wr_q.pop_front();
        if (core_wr_en !== mon_e.en || core_wr_addr !== mon_e.addr || core_wr_data !== mon_e.data) begin
          errors++;
          $display("FAIL write: en=%b addr=%0h data=%0h, required en=%b addr=%0h data=%0h",
                   core_wr_en, core_wr_addr, core_wr_data, mon_e.en, mon_e.addr, mon_e.data);
        end else begin
          $display("write en=%b addr=%0h ok", core_wr_en, core_wr_addr);
        end
      end
    end
    if (core_done != '0) begin
      checks++;
      if (done_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: core_done=%b, required none", core_done);
      end else begin
        mon_d = done_q.pop_front();
        if (core_done !== mon_d) begin
          errors++;
          $display("FAIL done: core_done=%b, required %b", core_done, mon_d);
        end else begin
          $display("done core_done=%b ok", core_done);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; sn_sof = 1'b0; snooper_wr_en = 1'b0; snooper_done = 1'b0;
    snooper_wr_addr = '0; snooper_wr_data = '0; core_ready = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sn_ready", 64'(sn_ready), 64'd1);
    chk("rst_grant_valid", 64'(grant_valid), 64'd0);
    chk("rst_cur_sel", 64'(cur_sel), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("rst_proto_err", 64'(proto_err), 64'd0);
    chk("rst_core_wr_en", 64'(core_wr_en), 64'd0);
    rst_n = 1'b1;

    // Round-robin over all-ready cores
    for (int c = 0; c < NC; c++) pkt(4'b1111, 4'b1111, 3, c);
    chk("rr_drop_cnt", 64'(drop_cnt), 64'd0);

    // Single ready core, then wrap past rr_ptr=3
    pkt(4'b0100, 4'b0100, 2, 2);
    pkt(4'b0011, 4'b0011, 1, 0);

    // Drops and saturation (4-bit counter here)
    pkt(4'b0000, 4'b0000, 5, -1);
    chk("drop_cnt_1", 64'(drop_cnt), 64'd1);
    for (int i = 0; i < 14; i++) pkt(4'b0000, 4'b0000, 0, -1);
    chk("drop_cnt_15", 64'(drop_cnt), 64'd15);
    pkt(4'b0000, 4'b0000, 1, -1);
    chk("drop_cnt_sat", 64'(drop_cnt), 64'd15);

    // Drops leave rr_ptr at 1; mid-packet ready loss; zero-write packet; wrap from core 3
    pkt(4'b1111, 4'b1111, 1, 1);
    pkt(4'b0010, 4'b0000, 3, 1);
    pkt(4'b1111, 4'b1111, 0, 2);
    pkt(4'b1001, 4'b1111, 1, 3);
    pkt(4'b1111, 4'b1111, 1, 0);

    // sof while granted
    do_reset();
    chk("proto_rst_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("proto_rst", 64'(proto_err), 64'd0);
    core_ready = 4'b1111;
    cyc(1'b1, 1'b0, 1'b0, -1);
    cyc(1'b0, 1'b1, 1'b0, 0);
    chk("proto_before", 64'(proto_err), 64'd0);
    cyc(1'b1, 1'b1, 1'b0, 0);
    cyc(1'b0, 1'b1, 1'b0, 0);
    cyc(1'b0, 1'b0, 1'b1, 0);
    cyc(1'b0, 1'b0, 1'b0, -1);
    chk("proto_sof_in_grant", 64'(proto_err), 64'd1);
    chk("proto_a_sn_ready", 64'(sn_ready), 64'd1);

    // done (and a write) while idle
    do_reset();
    cyc(1'b0, 1'b1, 1'b1, -1);
    cyc(1'b0, 1'b0, 1'b0, -1);
    chk("proto_done_idle", 64'(proto_err), 64'd1);
    chk("proto_b_grant_valid", 64'(grant_valid), 64'd0);

    // sof coincident with done
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, -1);
    cyc(1'b0, 1'b1, 1'b0, 0);
    cyc(1'b1, 1'b0, 1'b1, 0);
    cyc(1'b0, 1'b0, 1'b0, -1);
    chk("proto_sof_done", 64'(proto_err), 64'd1);
    chk("proto_c_grant_valid", 64'(grant_valid), 64'd0);
    pkt(4'b1111, 4'b1111, 1, 1);

    // Reset in the middle of a granted packet
    cyc(1'b1, 1'b0, 1'b0, -1);
    cyc(1'b0, 1'b1, 1'b0, 2);
    cyc(1'b0, 1'b1, 1'b0, 2);
    cyc(1'b0, 1'b1, 1'b0, -1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_wr_en", 64'(core_wr_en), 64'd0);
    chk("midrst_grant_valid", 64'(grant_valid), 64'd0);
    chk("midrst_sn_ready", 64'(sn_ready), 64'd1);
    cyc(1'b0, 1'b0, 1'b1, -1);
    chk("midrst_done", 64'(core_done), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; snooper_done = 1'b0;
    pkt(4'b1111, 4'b1111, 1, 0);
    cyc(1'b0, 1'b0, 1'b0, -1);
    chk("final_sn_ready", 64'(sn_ready), 64'd1);
    repeat (2) @(posedge clk);
    chk("wr_queue_empty", 64'(wr_q.size()), 64'd0);
    chk("done_queue_empty", 64'(done_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
